mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the backing array; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
REQ-002 Parameter WAIT_CYCLES, default 2, meaning extra stall cycles inserted between request acceptance and response, legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_address  input  32  byte address from executor.
REQ-006 mem_write_data  input  32  store data; byte/halfword values right-aligned in bits [7:0]/[15:0].
REQ-007 mem_read  input  1  load request, held high until memory_wait is seen low.
REQ-008 mem_write  input  1  store request, held high until memory_wait is seen low.
REQ-009 mem_size  input  3  funct3 of access: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 memory_read_data  output  32  load result, right-aligned (byte in [7:0], half in [15:0]), upper bits zero; extension done by executor.
REQ-011 memory_wait  output  1  high = executor must hold current instruction.
REQ-012 mem_fault  output  1  one-cycle pulse = access rejected (misaligned, out of range, illegal size, or read and write both high).

Function
REQ-013 States SHALL be IDLE, WAIT, RESP.
REQ-014 IDLE: if mem_read|mem_write high, memory_wait=1 combinationally; latch address, data, size, direction, fault flag; load counter=WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 IDLE with no request: memory_wait=0, stay IDLE.
REQ-016 WAIT: memory_wait=1; counter decrements each cycle; at counter==1 go RESP.
REQ-017 RESP: memory_wait=0; memory_read_data valid for loads; store committed at the RESP clock edge; next state IDLE unconditionally.
REQ-018 Total latency: request seen in cycle N, memory_wait low in cycle N+1+WAIT_CYCLES.
REQ-019 A new request present in the IDLE cycle immediately after RESP SHALL be accepted as a new transaction (back-to-back accesses allowed).
REQ-020 Load data: word read at address[31:2], shifted right by 8*address[1:0], masked to size width.
REQ-021 Store: byte enables B=0001<<addr[1:0], H=0011<<addr[1:0], W=1111; data lane = mem_write_data shifted left by 8*addr[1:0]; disabled bytes unchanged.
REQ-022 Fault conditions: H/HU with addr[0]=1; W with addr[1:0]!=0; address>=4*DEPTH_WORDS; mem_size 011/110/111; store with size BU/HU; mem_read&mem_write both high.
REQ-023 Faulted access: full latency still applied; in RESP mem_fault=1, memory_read_data=0, no array write.
REQ-024 Request deasserted during WAIT: abort, return IDLE next cycle, no write, no fault, memory_wait=0 in that cycle.
REQ-025 Request inputs changing during WAIT SHALL be ignored (latched values used).
REQ-026 memory_read_data SHALL be 0 in all states except RESP of a non-faulted load.

Reset
REQ-027 rst high at a clock edge: state IDLE, counter 0, latched registers 0, mem_fault 0.
REQ-028 Reset during WAIT or RESP SHALL discard the transaction with no array write.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 While rst high, memory_wait=0 and memory_read_data=0.

Verification
REQ-031 SW 0x0000_0010 data 0xDEAD_BEEF, WAIT_CYCLES=2 -> memory_wait high 3 cycles, low in 4th; subsequent LW 0x10 returns 0xDEAD_BEEF.
REQ-032 After REQ-031, SB 0x11 data 0x0000_0055 -> LW 0x10 returns 0xDEAD_55EF; LBU 0x13 returns 0x0000_00DE; LHU 0x12 returns 0x0000_DEAD.
REQ-033 LW 0x0000_0012 -> mem_fault pulses 1 cycle in RESP, memory_read_data 0; SH 0x13 -> fault, word at 0x10 unchanged.
REQ-034 LW at 4*DEPTH_WORDS -> mem_fault; mem_read and mem_write both high -> mem_fault, no write.
REQ-035 WAIT_CYCLES=0: back-to-back LW 0x10, LW 0x14 -> memory_wait pattern 1,0,1,0; both data correct.
REQ-036 SW 0x20 data 0x1234_5678 with rst asserted in WAIT -> after reset, LW 0x20 returns prior content (not 0x1234_5678); mem_fault 0.

Source files
------------

// File: rtl/mem_responder.sv
// Word-organised data memory answering executor loads/stores with a fixed stall
// latency, byte/halfword lanes, and a one-cycle fault pulse on rejected accesses.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_size,
    output logic [31:0] memory_read_data,
    output logic        memory_wait,
    output logic        mem_fault
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q;
    logic [1:0]      off_q;
    logic [31:0]     wdata_q;
    logic [2:0]      size_q;
    logic            write_q;
    logic            fault_q;
    logic            accept_c;
    logic            req_c;
    logic            req_fault_c;
    logic [3:0]      be_c;
    logic [31:0]     lane_c;
    logic [31:0]     word_c;
    logic [31:0]     shifted_c;
    logic [31:0]     load_c;

    logic [31:0] mem_array [DEPTH_WORDS];

    assign req_c = mem_read | mem_write;

    // Classify the incoming request; the verdict is latched with the transaction.
    always_comb begin
        req_fault_c = 1'b0;
        case (mem_size)
            SZ_B:    req_fault_c = 1'b0;
            SZ_H:    req_fault_c = mem_address[0];
            SZ_W:    req_fault_c = |mem_address[1:0];
            SZ_BU:   req_fault_c = mem_write;
            SZ_HU:   req_fault_c = mem_write | mem_address[0];
            default: req_fault_c = 1'b1;
        endcase
        if ({1'b0, mem_address} >= BYTE_LIMIT) begin
            req_fault_c = 1'b1;
        end
        if (mem_read && mem_write) begin
            req_fault_c = 1'b1;
        end
    end

    // Next state and stall; the stall drops in WAIT if the executor withdraws.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept_c    = 1'b0;
        memory_wait = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    accept_c    = 1'b1;
                    memory_wait = 1'b1;
                    cnt_d       = CW'(WAIT_CYCLES);
                    state_d     = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!req_c) begin
                    state_d = IDLE;
                end else begin
                    memory_wait = 1'b1;
                    cnt_d       = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            memory_wait = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_c) begin
                idx_q   <= mem_address[AW+1:2];
                off_q   <= mem_address[1:0];
                wdata_q <= mem_write_data;
                size_q  <= mem_size;
                write_q <= mem_write;
                fault_q <= req_fault_c;
            end
        end
    end

    // Store lanes: size_q[1:0] is 00 byte, 01 half, 10 word for legal stores.
    always_comb begin
        case (size_q[1:0])
            2'b00:   be_c = 4'b0001 << off_q;
            2'b01:   be_c = 4'b0011 << off_q;
            default: be_c = 4'b1111;
        endcase
        lane_c = wdata_q << {off_q, 3'b000};
    end

    // Array is deliberately not reset; the commit edge is the one ending RESP.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && write_q && !fault_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem_array[idx_q][8*i +: 8] <= lane_c[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        word_c    = mem_array[idx_q];
        shifted_c = word_c >> {off_q, 3'b000};
        case (size_q[1:0])
            2'b00:   load_c = {24'h0, shifted_c[7:0]};
            2'b01:   load_c = {16'h0, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

    assign memory_read_data = (!rst && state_q == RESP && !write_q && !fault_q) ? load_c : 32'h0;
    assign mem_fault        = !rst && state_q == RESP && fault_q;

endmodule
